// File: rtl/cache_pkg.sv
// ============================================================================
// Module : cache_pkg
// Brief  : Shared FSM state type and address-field width helpers for the
//          2-way set-associative data cache.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        REFILL    = 2'd3
    } state_t;

    function automatic int offset_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int words, input int sets);
        return addr_w - $clog2(words) - $clog2(sets);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_way.sv
// ============================================================================
// Module : cache_way
// Brief  : One way of the cache: per-set valid/dirty/tag bits and block data,
//          with an index lookup port and a word-write / block-refill port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_way
    import cache_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int WORDS    = 4,
    parameter  int SETS     = 4,
    parameter  int TAG_W    = 4,
    localparam int OFFSET_W = offset_w(WORDS),
    localparam int INDEX_W  = index_w(SETS),
    localparam int BLOCK_W  = DATA_W * WORDS
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [INDEX_W-1:0]  index,
    output logic                valid,
    output logic                dirty,
    output logic [TAG_W-1:0]    tag,
    output logic [BLOCK_W-1:0]  block,
    input  logic                word_we,
    input  logic [OFFSET_W-1:0] word_off,
    input  logic [DATA_W-1:0]   word_data,
    input  logic                refill_we,
    input  logic [TAG_W-1:0]    refill_tag,
    input  logic [BLOCK_W-1:0]  refill_block
);

    logic [SETS-1:0]    valid_q, valid_d;
    logic [SETS-1:0]    dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [BLOCK_W-1:0] data_q [SETS];

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign block = data_q[index];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (refill_we) begin
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
        end else if (word_we) begin
            dirty_d[index] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data need no reset: they are meaningless while valid is clear.
    always_ff @(posedge CLK) begin
        if (refill_we) begin
            tag_q[index]  <= refill_tag;
            data_q[index] <= refill_block;
        end else if (word_we) begin
            data_q[index][word_off*DATA_W +: DATA_W] <= word_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/assoc_dcache.sv
// ============================================================================
// Module : assoc_dcache
// Brief  : 2-way set-associative write-back, write-allocate data cache with
//          per-set LRU replacement and saturating hit/miss counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module assoc_dcache
    import cache_pkg::*;
#(
    parameter  int ADDR_W   = 8,
    parameter  int DATA_W   = 8,
    parameter  int WORDS    = 4,
    parameter  int SETS     = 4,
    parameter  int CNT_W    = 16,
    localparam int OFFSET_W = offset_w(WORDS)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       read,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W-1:0]          writedata,
    output logic [DATA_W-1:0]          readdata,
    output logic                       busywait,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-OFFSET_W-1:0] mem_address,
    output logic [DATA_W*WORDS-1:0]    mem_writedata,
    input  logic [DATA_W*WORDS-1:0]    mem_readdata,
    input  logic                       mem_busywait,
    output logic [CNT_W-1:0]           hit_count,
    output logic [CNT_W-1:0]           miss_count
);

    localparam int INDEX_W = index_w(SETS);
    localparam int TAG_W   = tag_w(ADDR_W, WORDS, SETS);
    localparam int BLOCK_W = DATA_W * WORDS;
    localparam int MADDR_W = ADDR_W - OFFSET_W;

    logic [OFFSET_W-1:0] offset;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;

    assign offset = address[OFFSET_W-1:0];
    assign index  = address[OFFSET_W +: INDEX_W];
    assign tag    = address[ADDR_W-1 -: TAG_W];

    state_t              state_q, state_d;
    logic [SETS-1:0]     lru_q, lru_d;
    logic                victim_q, victim_d;
    logic                retry_q, retry_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [MADDR_W-1:0]  mem_address_q, mem_address_d;
    logic [BLOCK_W-1:0]  mem_writedata_q, mem_writedata_d;
    logic [BLOCK_W-1:0]  fill_buf_q, fill_buf_d;
    logic [CNT_W-1:0]    hit_count_q, hit_count_d;
    logic [CNT_W-1:0]    miss_count_q, miss_count_d;

    logic [1:0]          way_valid, way_dirty, way_hit, way_word_we, way_refill_we;
    logic [TAG_W-1:0]    way_tag   [2];
    logic [BLOCK_W-1:0]  way_block [2];

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way #(
            .DATA_W (DATA_W),
            .WORDS  (WORDS),
            .SETS   (SETS),
            .TAG_W  (TAG_W)
        ) u_way (
            .CLK          (CLK),
            .RESET        (RESET),
            .index        (index),
            .valid        (way_valid[w]),
            .dirty        (way_dirty[w]),
            .tag          (way_tag[w]),
            .block        (way_block[w]),
            .word_we      (way_word_we[w]),
            .word_off     (offset),
            .word_data    (writedata),
            .refill_we    (way_refill_we[w]),
            .refill_tag   (tag),
            .refill_block (fill_buf_q)
        );
        assign way_hit[w]       = way_valid[w] && (way_tag[w] == tag);
        assign way_word_we[w]   = (state_q == IDLE) && write && way_hit[w];
        assign way_refill_we[w] = (state_q == REFILL) && (victim_q == 1'(w));
    end

    logic               access, hit, hit_way, idle_hit, victim_sel;
    logic [BLOCK_W-1:0] hit_block;

    assign access     = read | write;
    assign hit        = access && (way_hit != 2'b00);
    assign hit_way    = way_hit[1];
    assign idle_hit   = (state_q == IDLE) && hit;
    assign hit_block  = hit_way ? way_block[1] : way_block[0];
    assign victim_sel = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[index]);

    assign readdata      = idle_hit ? hit_block[offset*DATA_W +: DATA_W] : '0;
    assign busywait      = access && !idle_hit;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;

    always_comb begin
        state_d         = state_q;
        lru_d           = lru_q;
        victim_d        = victim_q;
        retry_d         = retry_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        fill_buf_d      = fill_buf_q;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    lru_d[index] = ~hit_way;
                    // The retry that completes a miss is not a separate hit.
                    if (retry_q)
                        retry_d = 1'b0;
                    else if (hit_count_q != '1)
                        hit_count_d = hit_count_q + 1'b1;
                end else if (access) begin
                    victim_d = victim_sel;
                    if (miss_count_q != '1)
                        miss_count_d = miss_count_q + 1'b1;
                    if (way_valid[victim_sel] && way_dirty[victim_sel]) begin
                        state_d         = WRITEBACK;
                        mem_write_d     = 1'b1;
                        mem_address_d   = {way_tag[victim_sel], index};
                        mem_writedata_d = way_block[victim_sel];
                    end else begin
                        state_d       = FETCH;
                        mem_read_d    = 1'b1;
                        mem_address_d = {tag, index};
                    end
                end
            end
            WRITEBACK: begin
                if (!mem_busywait) begin
                    state_d       = FETCH;
                    mem_write_d   = 1'b0;
                    mem_read_d    = 1'b1;
                    mem_address_d = {tag, index};
                end
            end
            FETCH: begin
                if (!mem_busywait) begin
                    state_d    = REFILL;
                    mem_read_d = 1'b0;
                    fill_buf_d = mem_readdata;
                end
            end
            REFILL: begin
                state_d = IDLE;
                retry_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= IDLE;
            lru_q           <= '0;
            victim_q        <= 1'b0;
            retry_q         <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            fill_buf_q      <= '0;
            hit_count_q     <= '0;
            miss_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            lru_q           <= lru_d;
            victim_q        <= victim_d;
            retry_q         <= retry_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            fill_buf_q      <= fill_buf_d;
            hit_count_q     <= hit_count_d;
            miss_count_q    <= miss_count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_assoc_dcache.sv
// ============================================================================
// Module : tb_assoc_dcache
// Brief  : Scoreboard bench for assoc_dcache against a flat-memory/LRU-list
//          reference model, with a latency-programmable block memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_assoc_dcache;

    localparam int NBLK = 64;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        read = 1'b0, write = 1'b0;
    logic [7:0]  address = '0, writedata = '0;
    logic [7:0]  readdata;
    logic        busywait, mem_read, mem_write, mem_busywait;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic [15:0] hit_count, miss_count;

    assoc_dcache dut (
        .CLK(CLK), .RESET(RESET), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            0: return 8'hAA;
            1: return 8'hBB;
            2: return 8'hCC;
            3: return 8'hDD;
            default: return 8'(a * 7 + 3);
        endcase
    endfunction

    // ---------------- block memory behind the cache ----------------
    logic [31:0] mem_blocks [NBLK];
    bit          mem_init_done = 0;
    bit          rand_lat = 0;
    int          mcnt = 0, mlat = 3, wb_seen = 0;
    logic [5:0]  last_fetch = 6'h3F, last_wb_addr = 6'h3F;
    logic [31:0] last_wb_data = '0;

    assign mem_busywait = (mem_read | mem_write) && (mcnt < mlat);
    assign mem_readdata = mem_blocks[mem_address];

    always @(posedge CLK) begin
        if (!mem_init_done) begin
            for (int b = 0; b < NBLK; b++)
                for (int w = 0; w < 4; w++)
                    mem_blocks[b][8*w +: 8] <= init_byte(b*4 + w);
            mem_init_done <= 1;
        end else if (RESET) begin
            mcnt <= 0;
        end else if (mem_read | mem_write) begin
            if (mcnt < mlat) begin
                mcnt <= mcnt + 1;
            end else begin
                if (mem_write) begin
                    mem_blocks[mem_address] <= mem_writedata;
                    last_wb_addr <= mem_address;
                    last_wb_data <= mem_writedata;
                    wb_seen      <= wb_seen + 1;
                end else begin
                    last_fetch <= mem_address;
                end
                mcnt <= 0;
                mlat <= rand_lat ? int'($urandom_range(0, 3)) : 3;
            end
        end
    end

    // ---------------- reference model ----------------
    // CPU view of memory, memory view after evictions, and per-set tags in
    // recency order (slot 0 most recent).
    logic [7:0]  ref_mem  [256];
    logic [31:0] mem_view [NBLK];
    int          nval [4];
    logic [3:0]  tagm [4][2];
    bit          dm   [4][2];
    int          m_hits = 0, m_misses = 0, m_wb = 0;

    task automatic model_access(input logic [7:0] a, input bit wr, input logic [7:0] d, output bit h);
        int s, found;
        logic [3:0] t, tt;
        bit dd;
        s = int'(a[3:2]);
        t = a[7:4];
        found = -1;
        for (int k = 0; k < nval[s]; k++)
            if (tagm[s][k] == t) found = k;
        if (found >= 0) begin
            h = 1;
            m_hits++;
            if (found == 1) begin
                tt = tagm[s][0]; dd = dm[s][0];
                tagm[s][0] = tagm[s][1]; dm[s][0] = dm[s][1];
                tagm[s][1] = tt; dm[s][1] = dd;
            end
        end else begin
            h = 0;
            m_misses++;
            if (nval[s] == 2 && dm[s][1]) begin
                m_wb++;
                for (int w = 0; w < 4; w++)
                    mem_view[{tagm[s][1], 2'(s)}][8*w +: 8] = ref_mem[{tagm[s][1], 2'(s), 2'(w)}];
            end
            tagm[s][1] = tagm[s][0]; dm[s][1] = dm[s][0];
            tagm[s][0] = t;          dm[s][0] = 0;
            if (nval[s] < 2) nval[s]++;
        end
        if (wr) begin
            dm[s][0]   = 1;
            ref_mem[a] = d;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) nval[s] = 0;
        m_hits = 0;
        m_misses = 0;
        for (int a = 0; a < 256; a++) ref_mem[a] = mem_view[a >> 2][8*(a & 3) +: 8];
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] data;
        bit         exp_hit;
    } exp_t;

    exp_t exp_q[$];
    int   busy_cyc = 0;

    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && (read || write)) begin
            if (busywait) begin
                busy_cyc++;
            end else begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got completion at addr %0h expected none", address);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_wr) check($sformatf("readdata@%0h", e.addr), readdata, e.data);
                    check($sformatf("no_stall@%0h", e.addr), busy_cyc == 0, e.exp_hit);
                end
                busy_cyc = 0;
            end
        end else begin
            busy_cyc = 0;
        end
    end

    // ---------------- driver ----------------
    task automatic finish_now(input string why);
        total++; bad++;
        $display("FAIL %s: got timeout expected completion", why);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic do_access(input logic [7:0] a, input bit wr, input bit both, input logic [7:0] d);
        exp_t e;
        bit   h, done;
        e.is_wr = wr;
        e.addr  = a;
        e.data  = ref_mem[a];
        model_access(a, wr, d, h);
        e.exp_hit = h;
        exp_q.push_back(e);
        @(posedge CLK); #1;
        address = a; writedata = d;
        write = wr; read = !wr || both;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK);
            if (!busywait) done = 1;
        end
        if (!done) finish_now("access_timeout");
        @(posedge CLK); #1;
        read = 0; write = 0;
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
    endtask

    initial begin
        int wbs, nbad;
        bit seen;
        for (int b = 0; b < NBLK; b++)
            for (int w = 0; w < 4; w++) mem_view[b][8*w +: 8] = init_byte(b*4 + w);
        model_reset();

        RESET = 1;
        repeat (3) @(posedge CLK);
        #1 RESET = 0;
        check("rst_readdata", readdata, 0);
        check("rst_busywait", busywait, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_writedata", mem_writedata, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);

        do_access(8'h00, 0, 0, 8'h00);
        check("cold_fetch_addr", last_fetch, 6'h00);
        do_access(8'h01, 0, 0, 8'h00);
        do_access(8'h00, 1, 0, 8'h55);
        do_access(8'h10, 0, 0, 8'h00);
        do_access(8'h01, 0, 0, 8'h00);
        wbs = wb_seen;
        do_access(8'h20, 0, 0, 8'h00);
        check("clean_evict_fetch", last_fetch, 6'h08);
        check("clean_evict_no_wb", wb_seen, wbs);
        do_access(8'h10, 0, 0, 8'h00);
        check("dirty_wb_addr", last_wb_addr, 6'h00);
        check("dirty_wb_data", last_wb_data, 32'hDDCCBB55);
        check("dirty_fetch", last_fetch, 6'h04);
        check("dirty_miss_count", miss_count, 4);

        // Reset while a fetch is outstanding.
        @(posedge CLK); #1;
        address = 8'h34; read = 1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK);
            if (mem_read) seen = 1;
        end
        check("midmiss_fetch_seen", seen, 1);
        @(posedge CLK); #1;
        RESET = 1; read = 0;
        @(posedge CLK); #1;
        RESET = 0;
        check("rst_mid_mem_read", mem_read, 0);
        check("rst_mid_mem_write", mem_write, 0);
        check("rst_mid_busywait", busywait, 0);
        check("rst_mid_hit_count", hit_count, 0);
        check("rst_mid_miss_count", miss_count, 0);
        exp_q.delete();
        model_reset();
        do_access(8'h00, 0, 0, 8'h00);

        rand_lat = 1;
        for (int n = 0; n < 400; n++) begin
            logic [7:0] a;
            bit wr;
            a  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            wr = ($urandom_range(0, 9) < 4);
            do_access(a, wr, wr && ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        check("writebacks", wb_seen, m_wb);
        nbad = 0;
        for (int b = 0; b < NBLK; b++)
            if (mem_blocks[b] !== mem_view[b]) nbad++;
        check("memory_image_mismatches", nbad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
